// File: rtl/fibo_pkg.sv
// Shared constants for the Fibonacci controller: ALU opcodes, register roles and FSM states.
package fibo_pkg;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_DEC  = 3'b110;

   localparam logic [1:0] REG_A   = 2'd0;
   localparam logic [1:0] REG_B   = 2'd1;
   localparam logic [1:0] REG_T   = 2'd2;
   localparam logic [1:0] REG_CNT = 2'd3;

   // One-hot so a corrupted state is detectable and falls back to IDLE.
   typedef enum logic [9:0] {
      ST_IDLE   = 10'b00_0000_0001,
      ST_LOAD_N = 10'b00_0000_0010,
      ST_INIT_A = 10'b00_0000_0100,
      ST_INIT_B = 10'b00_0000_1000,
      ST_CHECK  = 10'b00_0001_0000,
      ST_ADD    = 10'b00_0010_0000,
      ST_MOVE_A = 10'b00_0100_0000,
      ST_MOVE_B = 10'b00_1000_0000,
      ST_DEC    = 10'b01_0000_0000,
      ST_DONE   = 10'b10_0000_0000
   } state_t;

endpackage

// File: rtl/fibo_controller.sv
// Sequencing FSM that drives Fibo_Datapath through an iterative F(N) mod 2^SIZE computation.
//
// state   | meaning
// IDLE    | waiting for start, N latched on accept
// LOAD_N  | R3 <= N
// INIT_A  | R0 <= 0
// INIT_B  | R1 <= 1
// CHECK   | pass R3 through ALU; zero means N=0, finish early
// ADD     | R2 <= R0 + R1
// MOVE_A  | R0 <= R1
// MOVE_B  | R1 <= R2
// DEC     | R3 <= R3 - 1; loop until counter reaches zero
// DONE    | pass R0 through ALU, capture it into fib_out
module fibo_controller
   import fibo_pkg::*;
#(
   parameter int SIZE = 4
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] n_in,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] fib_out,
   output logic [1:0]      wrt_addr,
   output logic            wrt_en,
   output logic            load_data,
   output logic [1:0]      rd_addr1,
   output logic [1:0]      rd_addr2,
   output logic [SIZE-2:0] alu_opcode,
   output logic [SIZE-1:0] count,
   input  logic [SIZE-1:0] data,
   input  logic            zero_flag
);

   localparam int OPC_W = SIZE - 1;

   state_t          state_q;
   state_t          state_d;
   logic [SIZE-1:0] n_q;
   logic            capture;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         done    <= 1'b0;
         fib_out <= '0;
      end else begin
         state_q <= state_d;
         done    <= capture;
         if (capture) begin
            fib_out <= data;
         end
         if ((state_q == ST_IDLE) && start) begin
            n_q <= n_in;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      capture    = 1'b0;
      wrt_addr   = 2'd0;
      wrt_en     = 1'b0;
      load_data  = 1'b0;
      rd_addr1   = 2'd0;
      rd_addr2   = 2'd0;
      alu_opcode = '0;
      count      = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD_N;
            end
         end
         ST_LOAD_N: begin
            wrt_en    = 1'b1;
            load_data = 1'b1;
            wrt_addr  = REG_CNT;
            count     = n_q;
            state_d   = ST_INIT_A;
         end
         ST_INIT_A: begin
            wrt_en    = 1'b1;
            load_data = 1'b1;
            wrt_addr  = REG_A;
            count     = '0;
            state_d   = ST_INIT_B;
         end
         ST_INIT_B: begin
            wrt_en    = 1'b1;
            load_data = 1'b1;
            wrt_addr  = REG_B;
            count     = SIZE'(1);
            state_d   = ST_CHECK;
         end
         ST_CHECK: begin
            rd_addr1   = REG_CNT;
            alu_opcode = OPC_W'(ALU_PASS);
            state_d    = zero_flag ? ST_DONE : ST_ADD;
         end
         ST_ADD: begin
            wrt_en     = 1'b1;
            wrt_addr   = REG_T;
            rd_addr1   = REG_A;
            rd_addr2   = REG_B;
            alu_opcode = OPC_W'(ALU_ADD);
            state_d    = ST_MOVE_A;
         end
         ST_MOVE_A: begin
            wrt_en     = 1'b1;
            wrt_addr   = REG_A;
            rd_addr1   = REG_B;
            alu_opcode = OPC_W'(ALU_PASS);
            state_d    = ST_MOVE_B;
         end
         ST_MOVE_B: begin
            wrt_en     = 1'b1;
            wrt_addr   = REG_B;
            rd_addr1   = REG_T;
            alu_opcode = OPC_W'(ALU_PASS);
            state_d    = ST_DEC;
         end
         ST_DEC: begin
            // zero_flag reflects the decremented value being written this cycle
            wrt_en     = 1'b1;
            wrt_addr   = REG_CNT;
            rd_addr1   = REG_CNT;
            alu_opcode = OPC_W'(ALU_DEC);
            state_d    = zero_flag ? ST_DONE : ST_ADD;
         end
         ST_DONE: begin
            rd_addr1   = REG_A;
            alu_opcode = OPC_W'(ALU_PASS);
            capture    = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fibo_controller.sv
// Bench for fibo_controller: behavioural datapath, run-level reference model and directed scenarios.
module tb_fibo_controller;

   localparam int SIZE = 4;

   logic            Clk;
   logic            Rst_n;
   logic            start;
   logic [SIZE-1:0] n_in;
   logic            busy;
   logic            done;
   logic [SIZE-1:0] fib_out;
   logic [1:0]      wrt_addr;
   logic            wrt_en;
   logic            load_data;
   logic [1:0]      rd_addr1;
   logic [1:0]      rd_addr2;
   logic [SIZE-2:0] alu_opcode;
   logic [SIZE-1:0] count;
   logic [SIZE-1:0] data;
   logic            zero_flag;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   fibo_controller #(.SIZE(SIZE)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .start(start), .n_in(n_in),
      .busy(busy), .done(done), .fib_out(fib_out),
      .wrt_addr(wrt_addr), .wrt_en(wrt_en), .load_data(load_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .alu_opcode(alu_opcode),
      .count(count), .data(data), .zero_flag(zero_flag)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Datapath stand-in: 4-entry register file plus ALU
   logic [SIZE-1:0] rf [4];
   initial for (int i = 0; i < 4; i++) rf[i] = '0;

   always @(posedge Clk) begin
      if (wrt_en) rf[wrt_addr] <= load_data ? count : data;
   end

   always_comb begin
      data = '0;
      case (alu_opcode)
         3'b000:  data = rf[rd_addr1];
         3'b001:  data = rf[rd_addr1] + rf[rd_addr2];
         3'b110:  data = rf[rd_addr1] - 1'b1;
         default: data = '0;
      endcase
      zero_flag = (data == '0);
   end

   function automatic int fib_ref(input int n);
      int a;
      int b;
      int t;
      a = 0;
      b = 1;
      for (int i = 0; i < n; i++) begin
         t = (a + b) % 16;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Run-level model: a run occupies 4N+5 busy cycles, then one done cycle with F(N).
   int m_active = 0;
   int m_left   = 0;
   int m_done   = 0;
   int m_fib    = 0;
   int m_n      = 0;

   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         m_active = 0;
         m_left   = 0;
         m_done   = 0;
         m_fib    = 0;
      end else begin
         m_done = 0;
         if (m_active != 0) begin
            m_left--;
            if (m_left == 0) begin
               m_active = 0;
               m_done   = 1;
               m_fib    = fib_ref(m_n);
            end
         end else if (start) begin
            m_active = 1;
            m_n      = int'(n_in);
            m_left   = 4 * m_n + 5;
         end
      end
   end

   logic checking = 1'b0;

   always @(negedge Clk) begin
      if (checking) begin
         chk("busy", int'(busy), m_active);
         chk("done", int'(done), m_done);
         chk("fib_out", int'(fib_out), m_fib);
         if (m_active == 0) chk("wrt_en_idle", int'(wrt_en), 0);
      end
   end

   // Expected control vectors for N=1: {wrt_en, load_data, wrt_addr, count, rd_addr1, rd_addr2, alu_opcode}
   logic [14:0] trace [9];
   initial begin
      trace[0] = {1'b1, 1'b1, 2'd3, 4'd1, 2'd0, 2'd0, 3'd0};
      trace[1] = {1'b1, 1'b1, 2'd0, 4'd0, 2'd0, 2'd0, 3'd0};
      trace[2] = {1'b1, 1'b1, 2'd1, 4'd1, 2'd0, 2'd0, 3'd0};
      trace[3] = {1'b0, 1'b0, 2'd0, 4'd0, 2'd3, 2'd0, 3'd0};
      trace[4] = {1'b1, 1'b0, 2'd2, 4'd0, 2'd0, 2'd1, 3'd1};
      trace[5] = {1'b1, 1'b0, 2'd0, 4'd0, 2'd1, 2'd0, 3'd0};
      trace[6] = {1'b1, 1'b0, 2'd1, 4'd0, 2'd2, 2'd0, 3'd0};
      trace[7] = {1'b1, 1'b0, 2'd3, 4'd0, 2'd3, 2'd0, 3'd6};
      trace[8] = {1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 3'd0};
   end

   // Starts a run at a negedge; returns at the negedge of the done cycle (or when the bound expires).
   task automatic wait_done(input int c1, output int lat, output int nbusy);
      nbusy = 0;
      lat   = -1;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            lat = cyc - c1 + 1;
            return;
         end
         if (busy) nbusy++;
         @(negedge Clk);
      end
   endtask

   task automatic run(input int n, input int exp_fib, input string nm);
      int c1;
      int lat;
      int nb;
      start = 1'b1;
      n_in  = SIZE'(n);
      @(negedge Clk);
      start = 1'b0;
      c1 = cyc;
      wait_done(c1, lat, nb);
      chk({nm, "_latency"}, lat, 4 * n + 6);
      chk({nm, "_busy_cycles"}, nb, 4 * n + 5);
      chk({nm, "_fib_out"}, int'(fib_out), exp_fib);
   endtask

   initial begin
      int c1;
      int lat;
      int nb;
      int ndone;
      int dcyc [3];
      Rst_n = 1'b0;
      start = 1'b0;
      n_in  = '0;
      repeat (2) @(negedge Clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_fib_out", int'(fib_out), 0);
      chk("rst_wrt_en", int'(wrt_en), 0);
      #2 Rst_n = 1'b1;
      @(negedge Clk);
      checking = 1'b1;

      run(0, 0, "n0");

      // Control trace for N=1
      start = 1'b1;
      n_in  = 4'd1;
      @(negedge Clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("trace_n1_c%0d", i + 1),
             int'({wrt_en, load_data, wrt_addr, count, rd_addr1, rd_addr2, alu_opcode}),
             int'(trace[i]));
         @(negedge Clk);
      end
      chk("n1_done_c10", int'(done), 1);
      chk("n1_fib_out", int'(fib_out), 1);

      run(7, 13, "n7");
      run(15, 2, "n15");

      // Start pulse during an N=5 run must be ignored
      start = 1'b1;
      n_in  = 4'd5;
      @(negedge Clk);
      start = 1'b0;
      c1 = cyc;
      repeat (3) @(negedge Clk);
      start = 1'b1;
      n_in  = 4'd3;
      @(negedge Clk);
      start = 1'b0;
      n_in  = '0;
      wait_done(c1, lat, nb);
      chk("intr_latency", lat, 26);
      chk("intr_fib_out", int'(fib_out), 5);
      ndone = 0;
      repeat (30) begin
         @(negedge Clk);
         if (done) ndone++;
      end
      chk("intr_extra_done", ndone, 0);

      // Reset during the first DEC of an N=9 run
      start = 1'b1;
      n_in  = 4'd9;
      @(negedge Clk);
      start = 1'b0;
      repeat (7) @(negedge Clk);
      chk("n9_in_dec_addr", int'(wrt_addr), 3);
      chk("n9_in_dec_op", int'(alu_opcode), 6);
      #2 Rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_wrt_en", int'(wrt_en), 0);
      chk("abort_done", int'(done), 0);
      @(negedge Clk);
      #2 Rst_n = 1'b1;
      ndone = 0;
      repeat (50) begin
         @(negedge Clk);
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      run(6, 8, "n6");

      // Start held high: back-to-back N=2 runs
      start = 1'b1;
      n_in  = 4'd2;
      ndone = 0;
      for (int i = 0; i < 120 && ndone < 3; i++) begin
         @(negedge Clk);
         if (done) begin
            dcyc[ndone] = cyc;
            chk($sformatf("b2b_fib_out_%0d", ndone), int'(fib_out), 1);
            ndone++;
         end
      end
      start = 1'b0;
      chk("b2b_done_count", ndone, 3);
      if (ndone == 3) begin
         chk("b2b_gap_1", dcyc[1] - dcyc[0], 14);
         chk("b2b_gap_2", dcyc[2] - dcyc[1], 14);
      end
      repeat (20) @(negedge Clk);
      chk("final_idle", int'(busy), 0);

      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fibo_controller.md
Name: fibo_controller

Overview:
- Control FSM that sequences Fibo_Datapath to compute F(N) modulo 2^SIZE.
- Drives the datapath's write, read, ALU and load-data controls, and consumes the datapath's data and zero_flag outputs.
- Exposes a start/busy/done interface to the surrounding logic and returns the result in fib_out.
- Datapath register roles: R0 = a, R1 = b, R2 = temp, R3 = remaining-iteration counter.

Parameters:
SIZE, 4, datapath word width; alu_opcode is SIZE-1 bits wide, as in Fibo_Datapath.

Ports:
Clk  input  1  clock; all state changes on the rising edge
Rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
n_in  input  SIZE  term index N; captured together with start
busy  output  1  high in every state except IDLE
done  output  1  registered one-cycle pulse; fib_out is valid in the same cycle
fib_out  output  SIZE  registered result F(N) mod 2^SIZE; holds until the next done
wrt_addr  output  2  datapath register-file write address
wrt_en  output  1  datapath write enable
load_data  output  1  1 = datapath writes count; 0 = datapath writes the ALU result
rd_addr1  output  2  ALU operand A address
rd_addr2  output  2  ALU operand B address
alu_opcode  output  SIZE-1  ALU operation
count  output  SIZE  immediate value written to the register file when load_data=1
data  input  SIZE  datapath ALU result, combinational from the current control outputs
zero_flag  input  1  high when data == 0, combinational

Behaviour:
- Reset (asynchronous, Rst_n low): state=IDLE; done=0; fib_out=0; latched N=0. All datapath controls are 0, so wrt_en=0. A reset mid-computation aborts it with no done pulse.
- Datapath controls are a Moore decode of the registered state. Any field not listed below is 0.
- IDLE: no write. If start, latch n_in and go to LOAD_N.
- LOAD_N: wrt_en=1, load_data=1, wrt_addr=3, count=latched N. Go to INIT_A.
- INIT_A: wrt_en=1, load_data=1, wrt_addr=0, count=0. Go to INIT_B.
- INIT_B: wrt_en=1, load_data=1, wrt_addr=1, count=1. Go to CHECK.
- CHECK: wrt_en=0, rd_addr1=3, opcode=PASS. If zero_flag go to DONE, else go to ADD. This state handles N=0.
- ADD: wrt_addr=2, rd_addr1=0, rd_addr2=1, opcode=ADD. Writes R2 = R0+R1, wrapping mod 2^SIZE.
- MOVE_A: wrt_addr=0, rd_addr1=1, opcode=PASS. Writes R0 = R1.
- MOVE_B: wrt_addr=1, rd_addr1=2, opcode=PASS. Writes R1 = R2.
- DEC: wrt_addr=3, rd_addr1=3, opcode=DEC. Writes R3 = R3-1. If zero_flag (the new counter value is 0) go to DONE, else go to ADD.
- DONE: wrt_en=0, rd_addr1=0, opcode=PASS. On the exit edge: fib_out<=data, done<=1. Go to IDLE.
- done is a single-cycle pulse (done<=0 in all other cycles).
- Latency: done is high in cycle 4N+6 after the edge that samples start (N=0 gives 6).
- start is accepted in the same cycle done is high, since the FSM is already in IDLE.
- start while busy is ignored; n_in changes while busy are ignored.
- N=15 is the maximum; the counter never underflows because N=0 exits at CHECK.

Decomposition:
- Shared package fibo_pkg holds:
  - ALU opcode constants: ALU_PASS=3'b000, ALU_ADD=3'b001, ALU_DEC=3'b110.
  - Register index constants: REG_A=0, REG_B=1, REG_T=2, REG_CNT=3.
  - State encoding (one-hot-safe localparams).
- No sub-module; a single FSM with a registered output stage.
- The integration wrapper fibo_top instantiates fibo_controller and Fibo_Datapath.

Test Plan:
- Reset, then start with n_in=0 -> done high in cycle 6, fib_out=0, busy high for 5 cycles.
- n_in=1 -> control trace LOAD_N, INIT_A, INIT_B, CHECK, ADD, MOVE_A, MOVE_B, DEC, DONE; fib_out=1 in cycle 10.
- n_in=7 -> fib_out=13 in cycle 34. Then n_in=15 -> fib_out=2 (610 mod 16), checked against a reference model.
- Pulse start with n_in=3 in cycle 4 of an n_in=5 run -> ignored; single done with fib_out=5.
- Deassert Rst_n mid-DEC of an n_in=9 run -> immediately state IDLE, wrt_en=0, busy=0, no done. Then n_in=6 -> fib_out=8.
- Hold start high continuously with n_in=2 -> back-to-back runs; done pulses exactly 14 cycles apart (4N+6), each with fib_out=1.
